// File: rtl/PECfg.sv
// Shared PE array geometry and sequencer counter widths.
package PECfg;

  localparam int PEROW = 4;
  localparam int TAPW  = 4;
  localparam int ITERW = 8;

endpackage : PECfg

// File: rtl/PECtlCfg.sv
// Job descriptor, sequencer state and MultStage control-beat layout.
package PECtlCfg;

  typedef struct packed {
    logic [PECfg::TAPW-1:0]  num_tap;
    logic [PECfg::ITERW-1:0] num_iter;
    logic [PECfg::PEROW-1:0] row_en;
  } PESeqCfg;

  typedef struct packed {
    logic                    clr;
    logic                    last;
    logic [PECfg::TAPW-1:0]  tap;
    logic [PECfg::PEROW-1:0] row_en;
  } MSctl;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // Build one control beat: clear on the first tap, last on the final tap.
  function automatic MSctl ms_beat(input logic [PECfg::TAPW-1:0]  tap,
                                   input logic [PECfg::TAPW-1:0]  num_tap,
                                   input logic [PECfg::PEROW-1:0] row_en);
    MSctl beat;
    beat.clr    = (tap == {PECfg::TAPW{1'b0}});
    beat.last   = (tap == num_tap);
    beat.tap    = tap;
    beat.row_en = row_en;
    return beat;
  endfunction

endpackage : PECtlCfg

// File: rtl/pe_seq_ctl.sv
// PE tap/iteration sequencer: turns one job descriptor into a stream of
// MultStage control beats and waits for every issued beat to drain.
module pe_seq_ctl
  import PECtlCfg::*;
#(
  parameter int PEROW = PECfg::PEROW,
  parameter int TAPW  = PECfg::TAPW,
  parameter int ITERW = PECfg::ITERW
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    cfg_rdy,
  output logic    cfg_ack,
  input  PESeqCfg i_cfg,
  output logic    ctl_rdy,
  input  logic    ctl_ack,
  output MSctl    o_ctl,
  input  logic    i_ms_fire,
  output logic    o_busy,
  output logic    o_done
);

  localparam int CNTW = TAPW + ITERW + 1;
  localparam logic [CNTW-1:0]  CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0]  CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [TAPW-1:0]  TAP_ZERO  = {TAPW{1'b0}};
  localparam logic [TAPW-1:0]  TAP_ONE   = {{(TAPW-1){1'b0}}, 1'b1};
  localparam logic [ITERW-1:0] ITER_ZERO = {ITERW{1'b0}};
  localparam logic [ITERW-1:0] ITER_ONE  = {{(ITERW-1){1'b0}}, 1'b1};

  seq_state_e       state_r, state_nxt_s;
  logic [TAPW-1:0]  num_tap_r;
  logic [ITERW-1:0] num_iter_r;
  logic [PEROW-1:0] row_en_r;
  logic [TAPW-1:0]  tap_r, tap_nxt_s;
  logic [ITERW-1:0] iter_r, iter_nxt_s;
  logic [CNTW-1:0]  outst_r, outst_nxt_s;
  logic             ctl_rdy_r;
  MSctl             ctl_r, ctl_nxt_s;
  logic             busy_r;
  logic             cfg_xfer_s, ctl_xfer_s, fire_s, last_tap_s;

  assign cfg_ack    = (state_r == ST_IDLE);
  // The first IDLE cycle after a job is the only one where busy still lags.
  assign o_done     = (state_r == ST_IDLE) && busy_r;
  assign ctl_rdy    = ctl_rdy_r;
  assign o_ctl      = ctl_r;
  assign o_busy     = busy_r;

  assign cfg_xfer_s = cfg_ack && cfg_rdy;
  assign ctl_xfer_s = ctl_rdy_r && ctl_ack;
  assign fire_s     = i_ms_fire && (outst_r != CNT_ZERO);
  assign last_tap_s = (tap_r == num_tap_r);

  // Outstanding beat tracker: issued minus returned, floored at zero.
  always_comb begin
    outst_nxt_s = outst_r;
    if (state_r == ST_LOAD) begin
      outst_nxt_s = CNT_ZERO;
    end else if (ctl_xfer_s && !fire_s) begin
      outst_nxt_s = outst_r + CNT_ONE;
    end else if (!ctl_xfer_s && fire_s) begin
      outst_nxt_s = outst_r - CNT_ONE;
    end else begin
      outst_nxt_s = outst_r;
    end
  end

  // Tap/iteration counters advance on each accepted control beat.
  always_comb begin
    tap_nxt_s  = tap_r;
    iter_nxt_s = iter_r;
    case (state_r)
      ST_LOAD: begin
        tap_nxt_s  = TAP_ZERO;
        iter_nxt_s = ITER_ZERO;
      end
      ST_ISSUE: begin
        if (ctl_xfer_s && last_tap_s) begin
          tap_nxt_s  = TAP_ZERO;
          iter_nxt_s = iter_r + ITER_ONE;
        end else if (ctl_xfer_s) begin
          tap_nxt_s  = tap_r + TAP_ONE;
        end else begin
          tap_nxt_s  = tap_r;
        end
      end
      default: begin
        tap_nxt_s  = tap_r;
        iter_nxt_s = iter_r;
      end
    endcase
  end

  // Next-state decode and the next control beat presented to MultStage.
  always_comb begin
    state_nxt_s = state_r;
    ctl_nxt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_xfer_s) state_nxt_s = ST_LOAD;
        else            state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_ISSUE;
      ST_ISSUE: begin
        if (ctl_xfer_s && last_tap_s && (iter_r == num_iter_r)) state_nxt_s = ST_DRAIN;
        else                                                    state_nxt_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (outst_nxt_s == CNT_ZERO) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (state_nxt_s == ST_ISSUE) begin
      ctl_nxt_s = ms_beat(tap_nxt_s, num_tap_r, row_en_r);
    end else begin
      ctl_nxt_s = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      tap_r     <= TAP_ZERO;
      iter_r    <= ITER_ZERO;
      outst_r   <= CNT_ZERO;
      ctl_rdy_r <= 1'b0;
      ctl_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tap_r     <= tap_nxt_s;
      iter_r    <= iter_nxt_s;
      outst_r   <= outst_nxt_s;
      ctl_rdy_r <= (state_nxt_s == ST_ISSUE);
      ctl_r     <= ctl_nxt_s;
      busy_r    <= (state_r != ST_IDLE);
    end
  end

  // Job descriptor latch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      num_tap_r  <= TAP_ZERO;
      num_iter_r <= ITER_ZERO;
      row_en_r   <= {PEROW{1'b0}};
    end else if (cfg_xfer_s) begin
      num_tap_r  <= i_cfg.num_tap;
      num_iter_r <= i_cfg.num_iter;
      row_en_r   <= i_cfg.row_en;
    end else begin
      num_tap_r  <= num_tap_r;
      num_iter_r <= num_iter_r;
      row_en_r   <= row_en_r;
    end
  end

endmodule : pe_seq_ctl

// File: doc/pe_seq_ctl.md
PE_SEQ_CTL -- requirements
Module: pe_seq_ctl

Interface
REQ-001 Parameter PEROW, default PECfg::PEROW, number of PE rows driven by one control beat.
REQ-002 Parameter TAPW, default 4, tap-count width; taps per accumulation are 1..2^TAPW.
REQ-003 Parameter ITERW, default 8, iteration-count width; accumulations per job are 1..2^ITERW.
REQ-004 Port i_clk  in  1  clock; the block uses one clock.
REQ-005 Port i_rst  in  1  reset; asynchronous, active-high.
REQ-006 Port cfg_rdy  in  1  job descriptor valid.
REQ-007 Port cfg_ack  out  1  job descriptor accepted.
REQ-008 Port i_cfg  in  PESeqCfg  fields: num_tap (TAPW, value minus 1), num_iter (ITERW, value minus 1), row_en (PEROW).
REQ-009 Port ctl_rdy  out  1  control beat valid toward the MultStage pipe.
REQ-010 Port ctl_ack  in  1  control beat consumed.
REQ-011 Port o_ctl  out  MSctl  fields: clr, last, tap (TAPW), row_en (PEROW).
REQ-012 Port i_ms_fire  in  1  one-cycle pulse per MultStage output beat (MS_rdy && MS_ack).
REQ-013 Port o_busy  out  1  job in progress (any state other than IDLE).
REQ-014 Port o_done  out  1  one-cycle pulse when the job has fully drained.

Function
REQ-015 Handshakes: a transfer occurs on a cycle where rdy && ack; once rdy rises, rdy and its data stay stable until the transfer occurs.
REQ-016 The FSM has four states: IDLE, LOAD, ISSUE, DRAIN.
REQ-017 IDLE: cfg_ack = 1; a cfg transfer latches i_cfg and moves the FSM to LOAD.
REQ-018 LOAD: one cycle; clears the tap, iteration and outstanding counters, then moves to ISSUE.
REQ-019 ISSUE: ctl_rdy = 1 from the first ISSUE cycle.
REQ-020 ISSUE beat fields: o_ctl.tap = tap counter; clr = (tap == 0); last = (tap == num_tap); row_en = the latched row_en.
REQ-021 Each ctl transfer increments tap; at tap == num_tap, tap wraps to 0 and iter increments.
REQ-022 A transfer with last && iter == num_iter moves the FSM to DRAIN; ctl_rdy deasserts in the same transfer cycle's next cycle.
REQ-023 Total beats per job = (num_tap+1)*(num_iter+1); max 16*256 = 4096 with the defaults.
REQ-024 A tap-1 job (num_tap = 0) issues beats with clr = last = 1 on every beat.
REQ-025 Outstanding counter (width TAPW+ITERW+1): +1 per ctl transfer, -1 per i_ms_fire, unchanged when both occur in the same cycle, no change otherwise.
REQ-026 Outstanding must never underflow; an i_ms_fire while the counter is 0 is ignored.
REQ-027 DRAIN: when outstanding == 0 (including a final decrement landing at 0 that cycle), o_done pulses for one cycle and the FSM returns to IDLE.
REQ-028 cfg_rdy during LOAD, ISSUE or DRAIN is not acknowledged (cfg_ack = 0) and is held by the sender.
REQ-029 A new cfg is accepted in the first IDLE cycle after o_done; back-to-back jobs have a one-cycle IDLE bubble.
REQ-030 Output timing: o_busy and ctl_rdy are registered; cfg_ack and o_done are decoded from state; there is no combinational path from ctl_ack to ctl_rdy.

Reset
REQ-031 i_rst asserts asynchronously and forces: state = IDLE; all counters and the cfg register = 0; ctl_rdy, o_busy, o_done = 0; o_ctl = '0; cfg_ack = 1 after release.
REQ-032 Reset mid-job abandons the job with no o_done; outstanding beats are forgotten.

Structure
REQ-033 PESeqCfg, the state enum and the o_ctl field layout (MSctl) live in package PECtlCfg; TAPW and ITERW defaults live in PECfg.
REQ-034 The block is a single flat module; the outstanding tracker is inline (no sub-module).
REQ-035 The block instantiates no datapath; MultStage consumes o_ctl as its i_ctl stream.

Verification
REQ-036 Scenario: num_tap=2, num_iter=1, ctl_ack held 1 -> 6 beats; tap sequence 0,1,2,0,1,2; clr on beats 1 and 4; last on beats 3 and 6; then DRAIN.
REQ-037 Scenario: i_ms_fire issued 3 cycles after each beat -> o_done fires exactly one cycle after the 6th fire; o_busy drops the following cycle.
REQ-038 Scenario: ctl_ack toggled pseudo-randomly -> o_ctl stable while ctl_rdy && !ctl_ack; same 6-beat sequence as REQ-036.
REQ-039 Scenario: num_tap=0, num_iter=0 -> a single beat with clr = last = 1; o_done after a single i_ms_fire.
REQ-040 Scenario: ctl transfer and i_ms_fire in the same cycle -> outstanding unchanged; a spurious i_ms_fire in IDLE -> no effect.
REQ-041 Scenario: i_rst pulsed mid-ISSUE (beat 3 of 6) -> all outputs reset immediately; no o_done; the next cfg is accepted normally.
